issue_queue: RTL and testbench
==============================

Name: issue_queue

Overview:
Parametrised successor to the dual-issue stage: a circular instruction buffer with a 2-wide push from fetch and 0/1/2-wide in-order issue to the two decode pipes.
- Pairing rules, delay-slot tracking and the TLB refetch tag are computed from per-entry pre-decoded metadata held in the queue.
- Depth, payload width and dual/single issue mode are parameters.
- Sits between the fetch/predecode stage and iduc/idup.

Parameters:
DATA_W, 99, payload width per entry (pred_taken, pred_target, itlb flags, pc, inst)
DEPTH, 16, entries; power of two, >=4
DUAL_ISSUE, 1, 1 = slot 2 may issue; 0 = slot 2 never issues

Ports:
clk  in  1  clock
rst  in  1  reset
push_num  in  2  entries pushed this cycle: 0/1/2 (3 treated as 0)
push_data  in  2*DATA_W  lane0 = [DATA_W-1:0], older; lane1 = upper
push_meta  in  2*19  per lane: [18]jmp [17]solo [16]serial [15]w_ena [14:10]w_dst [9:5]rs [4:0]rt; lane0 low
push_ready  out  1  free entries >= 2
stall  in  1  downstream stall; no issue
flush  in  1  empty queue, clear in_ds
refetch_clr  in  1  clear refetch tag
out_valid_1  out  1  slot 1 issues this cycle (pop)
out_data_1  out  DATA_W  head payload
out_in_ds_1  out  1  slot 1 is a delay slot
out_valid_2  out  1  slot 2 issues this cycle
out_data_2  out  DATA_W  head+1 payload
out_in_ds_2  out  1  slot 2 is a delay slot
out_refetch  out  1  refetch tag for both slots
perf_single_cnt  out  32  single-issue cycles
perf_dual_cnt  out  32  dual-issue cycles
perf_empty_cnt  out  32  cycles with ~stall and empty queue

Behaviour:
- Reset: rst is synchronous, active-high; clock is clk.
- Reset values: count = 0, rd_ptr = wr_ptr = 0, in_ds = 0, refetch = 0.
- Consequences at reset: out_valid_1/2 = 0, push_ready = 1, out_in_ds_1/2 = 0, out_refetch = 0, perf counters = 0.
- Storage: count width log2(DEPTH)+1; pointers wrap modulo DEPTH.
- Push:
  - Accepted only when push_ready (DEPTH-count >= 2). A push with push_ready = 0 is dropped; no state change.
  - Lane0 is written at wr_ptr, lane1 at wr_ptr+1.
- Issue outputs are combinational from head entries and registers.
  - Pushed data is visible at earliest the next cycle; no bypass.
- out_valid_1 = ~stall & ~flush & count >= 1.
- out_valid_2 = out_valid_1 & DUAL_ISSUE & count >= 2 & ~in_ds & ~raw & ~jmp(h1) & ~solo(h1) & ~serial(h0) & ~serial(h1).
  - raw = w_ena(h0) & ((w_dst(h0) == rs(h1) & rs(h1) != 0) | (w_dst(h0) == rt(h1) & rt(h1) != 0)).
- Pop: rd_ptr += out_valid_1 + out_valid_2.
  - count_next = count + accepted_push - popped.
  - Simultaneous push and pop is legal.
- flush: count = 0, rd_ptr = wr_ptr, in_ds = 0. Same-cycle push is discarded. Flush has priority over push/pop.
- in_ds:
  - flush → 0.
  - else if out_valid_1 → jmp(h0) & ~out_valid_2.
  - else hold. This covers stall and empty, so a jump issued alone keeps its delay-slot flag across bubbles.
- out_in_ds_1 = in_ds.
- out_in_ds_2 = jmp(h0) & out_valid_2.
- refetch_next = (out_valid_1 & serial(h0)) | (out_valid_2 & serial(h1)) | (refetch & ~refetch_clr).
  - Set wins over clear.
  - Not affected by flush.
- out_refetch = refetch.
- Meta bits:
  - solo = may only issue in slot 1 (hilo, cop0, ls, check_ov, adel, itlb exception).
  - serial = nothing may pair behind it, and it sets refetch (tlbr/tlbwi/tlbp).

Optional Feature:
ISSUE_PERF_EN
- Defined:
  - perf_single_cnt increments when out_valid_1 & ~out_valid_2.
  - perf_dual_cnt increments when out_valid_2.
  - perf_empty_cnt increments when ~stall & count == 0.
  - All 32-bit, wrap at 2^32, cleared by rst.
- Undefined: the three ports are tied to 32'h0 and no counter flops are inferred.

Test Plan:
- Reset, then push 2 independent ALU entries (rs = 1, rt = 2, w_dst = 3) → next cycle out_valid_1 = out_valid_2 = 1, count returns to 0, push_ready = 1.
- Head w_ena = 1, w_dst = 5, next entry rs = 5 → only slot 1 issues. Repeat with rs = 0, w_dst = 0 → dual issue.
- Jump issued alone (count = 1), stall 3 cycles, then push its delay slot → slot 1 issues with out_in_ds_1 = 1, and in_ds clears afterwards. Jump paired with a delay slot → out_in_ds_2 = 1.
- Fill to DEPTH = 16: push_ready drops at count = 15, and a push at count = 15 is dropped. Then flush with simultaneous push → count = 0, nothing issues next cycle.
- Issue a serial entry → out_refetch = 1 from the next cycle until refetch_clr, and stays 1 if refetch_clr and a new serial issue occur together. With DUAL_ISSUE = 0, out_valid_2 stays 0 throughout.
- With ISSUE_PERF_EN, 10 dual cycles, 4 single cycles and 3 idle unstalled cycles → counters read 10/4/3. Without the macro, all read 0.

Source files
------------

// File: rtl/issue_queue_if.sv
// Issue queue handshake bundle: 2-wide push from fetch/predecode, two issue
// slots towards iduc/idup, control strobes and performance counters.
// master = fetch/control side, slave = the queue itself.
interface issue_queue_if #(
  parameter int DATA_W = 99
);
  logic [1:0]          push_num;
  logic [2*DATA_W-1:0] push_data;
  logic [2*19-1:0]     push_meta;
  logic                push_ready;
  logic                stall;
  logic                flush;
  logic                refetch_clr;
  logic                out_valid_1;
  logic [DATA_W-1:0]   out_data_1;
  logic                out_in_ds_1;
  logic                out_valid_2;
  logic [DATA_W-1:0]   out_data_2;
  logic                out_in_ds_2;
  logic                out_refetch;
  logic [31:0]         perf_single_cnt;
  logic [31:0]         perf_dual_cnt;
  logic [31:0]         perf_empty_cnt;

  modport master (
    output push_num, push_data, push_meta, stall, flush, refetch_clr,
    input  push_ready, out_valid_1, out_data_1, out_in_ds_1,
           out_valid_2, out_data_2, out_in_ds_2, out_refetch,
           perf_single_cnt, perf_dual_cnt, perf_empty_cnt
  );

  modport slave (
    input  push_num, push_data, push_meta, stall, flush, refetch_clr,
    output push_ready, out_valid_1, out_data_1, out_in_ds_1,
           out_valid_2, out_data_2, out_in_ds_2, out_refetch,
           perf_single_cnt, perf_dual_cnt, perf_empty_cnt
  );
endinterface

// File: rtl/issue_queue.sv
// Circular instruction buffer between fetch/predecode and the two decode pipes.
// 2-wide push, 0/1/2-wide in-order issue. Pairing, delay-slot and TLB refetch
// decisions come from per-entry predecoded metadata stored beside the payload.
// Meta layout per lane: [18]jmp [17]solo [16]serial [15]w_ena [14:10]w_dst
// [9:5]rs [4:0]rt.
// Optional build macro ISSUE_PERF_EN enables the three 32-bit perf counters;
// without it the counter ports read zero and no counter flops exist.
module issue_queue #(
  parameter int DATA_W     = 99,
  parameter int DEPTH      = 16,
  parameter int DUAL_ISSUE = 1
) (
  input logic          clk,
  input logic          rst,
  issue_queue_if.slave bus
);
  localparam int   AW      = $clog2(DEPTH);
  localparam int   CW      = AW + 1;
  localparam int   MW      = 19;
  localparam logic DUAL_EN = (DUAL_ISSUE != 0);

  logic [DATA_W-1:0] data_mem [DEPTH];
  logic [MW-1:0]     meta_mem [DEPTH];

  logic [AW-1:0] rd_ptr;
  logic [AW-1:0] wr_ptr;
  logic [AW-1:0] rd_ptr_1;
  logic [AW-1:0] wr_ptr_1;
  logic [CW-1:0] count;
  logic          in_ds;
  logic          refetch;

  logic [MW-1:0] meta_h0;
  logic [MW-1:0] meta_h1;
  logic          push_ready;
  logic [1:0]    push_n;
  logic [1:0]    pop_n;
  logic          raw;
  logic          valid_1;
  logic          valid_2;
  logic          jmp_h0;
  logic          serial_h0;
  logic          serial_h1;

  assign rd_ptr_1 = rd_ptr + AW'(1);
  assign wr_ptr_1 = wr_ptr + AW'(1);

  assign push_ready = (count <= CW'(DEPTH - 2));

  // A value of 3 on push_num is treated as no push; flush discards the push.
  assign push_n = (bus.flush || !push_ready || bus.push_num == 2'd3) ? 2'd0 : bus.push_num;

  assign meta_h0   = meta_mem[rd_ptr];
  assign meta_h1   = meta_mem[rd_ptr_1];
  assign jmp_h0    = meta_h0[18];
  assign serial_h0 = meta_h0[16];
  assign serial_h1 = meta_h1[16];

  // Read-after-write between the pair; register 0 never creates a hazard.
  assign raw = meta_h0[15] &
               (((meta_h0[14:10] == meta_h1[9:5]) && (meta_h1[9:5] != 5'd0)) ||
                ((meta_h0[14:10] == meta_h1[4:0]) && (meta_h1[4:0] != 5'd0)));

  assign valid_1 = !bus.stall && !bus.flush && (count != '0);
  assign valid_2 = valid_1 && DUAL_EN && (count >= CW'(2)) && !in_ds && !raw &&
                   !meta_h1[18] && !meta_h1[17] && !serial_h0 && !serial_h1;

  assign pop_n = {1'b0, valid_1} + {1'b0, valid_2};

  assign bus.push_ready  = push_ready;
  assign bus.out_valid_1 = valid_1;
  assign bus.out_data_1  = data_mem[rd_ptr];
  assign bus.out_in_ds_1 = in_ds;
  assign bus.out_valid_2 = valid_2;
  assign bus.out_data_2  = data_mem[rd_ptr_1];
  assign bus.out_in_ds_2 = jmp_h0 && valid_2;
  assign bus.out_refetch = refetch;

  // Payload and metadata storage; lane0 is the older entry and lands first.
  always_ff @(posedge clk) begin
    if (push_n != 2'd0) begin
      data_mem[wr_ptr] <= bus.push_data[DATA_W-1:0];
      meta_mem[wr_ptr] <= bus.push_meta[MW-1:0];
    end
    if (push_n == 2'd2) begin
      data_mem[wr_ptr_1] <= bus.push_data[2*DATA_W-1:DATA_W];
      meta_mem[wr_ptr_1] <= bus.push_meta[2*MW-1:MW];
    end
  end

  // Pointers, occupancy, delay-slot and refetch tracking. Flush wins over
  // push/pop but leaves the refetch tag alone; a jump issued alone keeps its
  // delay-slot flag across stalls and empty bubbles.
  always_ff @(posedge clk) begin
    if (rst) begin
      count   <= '0;
      rd_ptr  <= '0;
      wr_ptr  <= '0;
      in_ds   <= 1'b0;
      refetch <= 1'b0;
    end else begin
      if (bus.flush) begin
        count  <= '0;
        rd_ptr <= wr_ptr;
        in_ds  <= 1'b0;
      end else begin
        count  <= count + CW'(push_n) - CW'(pop_n);
        rd_ptr <= rd_ptr + AW'(pop_n);
        wr_ptr <= wr_ptr + AW'(push_n);
        if (valid_1) in_ds <= jmp_h0 && !valid_2;
      end
      refetch <= (valid_1 && serial_h0) || (valid_2 && serial_h1) ||
                 (refetch && !bus.refetch_clr);
    end
  end

`ifdef ISSUE_PERF_EN
  logic [31:0] single_cnt;
  logic [31:0] dual_cnt;
  logic [31:0] empty_cnt;

  // Issue-width and idle statistics, free-running with natural wrap.
  always_ff @(posedge clk) begin
    if (rst) begin
      single_cnt <= '0;
      dual_cnt   <= '0;
      empty_cnt  <= '0;
    end else begin
      if (valid_1 && !valid_2)             single_cnt <= single_cnt + 32'd1;
      if (valid_2)                         dual_cnt   <= dual_cnt + 32'd1;
      if (!bus.stall && (count == '0))     empty_cnt  <= empty_cnt + 32'd1;
    end
  end

  assign bus.perf_single_cnt = single_cnt;
  assign bus.perf_dual_cnt   = dual_cnt;
  assign bus.perf_empty_cnt  = empty_cnt;
`else
  assign bus.perf_single_cnt = 32'h0;
  assign bus.perf_dual_cnt   = 32'h0;
  assign bus.perf_empty_cnt  = 32'h0;
`endif

endmodule

// File: tb/tb_issue_queue.sv
// Directed bench for issue_queue: a dual-issue instance takes the stimulus,
// a single-issue instance mirrors the same inputs.
module tb_issue_queue;
  localparam int DW = 99;
`ifdef ISSUE_PERF_EN
  localparam bit PERF = 1'b1;
`else
  localparam bit PERF = 1'b0;
`endif

  localparam logic [18:0] M_ALU  = {4'b0001, 5'd3, 5'd1, 5'd2};
  localparam logic [18:0] M_JMP  = {4'b1000, 5'd0, 5'd0, 5'd0};
  localparam logic [18:0] M_SER  = {4'b0010, 5'd0, 5'd0, 5'd0};
  localparam logic [18:0] M_SOLO = {4'b0100, 5'd0, 5'd0, 5'd0};

  logic clk = 1'b0;
  logic rst;
  int   vec  = 0;
  int   errs = 0;

  always #5 clk = ~clk;

  issue_queue_if #(.DATA_W(DW)) bus_a ();
  issue_queue_if #(.DATA_W(DW)) bus_b ();

  issue_queue #(.DATA_W(DW), .DEPTH(16), .DUAL_ISSUE(1)) dut_a (.clk(clk), .rst(rst), .bus(bus_a));
  issue_queue #(.DATA_W(DW), .DEPTH(16), .DUAL_ISSUE(0)) dut_b (.clk(clk), .rst(rst), .bus(bus_b));

  assign bus_b.push_num    = bus_a.push_num;
  assign bus_b.push_data   = bus_a.push_data;
  assign bus_b.push_meta   = bus_a.push_meta;
  assign bus_b.stall       = bus_a.stall;
  assign bus_b.flush       = bus_a.flush;
  assign bus_b.refetch_clr = bus_a.refetch_clr;

  function automatic logic [DW-1:0] dat(int n);
    return {35'h0, 32'hA5A5_0000 | n, n};
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic set_push(logic [1:0] n, logic [DW-1:0] d0, logic [18:0] m0,
                          logic [DW-1:0] d1, logic [18:0] m1);
    bus_a.push_num  = n;
    bus_a.push_data = {d1, d0};
    bus_a.push_meta = {m1, m0};
  endtask

  task automatic do_reset();
    rst = 1'b1;
    bus_a.stall = 1'b0;
    bus_a.flush = 1'b0;
    bus_a.refetch_clr = 1'b0;
    set_push(2'd0, '0, '0, '0, '0);
    tick();
    tick();
    rst = 1'b0;
  endtask

  task automatic test_reset();
    do_reset();
    #1;
    vec++; if (bus_a.out_valid_1 !== 1'b0) begin errs++; $display("FAIL reset_v1 got %0b exp 0", bus_a.out_valid_1); end
    vec++; if (bus_a.out_valid_2 !== 1'b0) begin errs++; $display("FAIL reset_v2 got %0b exp 0", bus_a.out_valid_2); end
    vec++; if (bus_a.push_ready !== 1'b1) begin errs++; $display("FAIL reset_ready got %0b exp 1", bus_a.push_ready); end
    vec++; if (bus_a.out_in_ds_1 !== 1'b0) begin errs++; $display("FAIL reset_ds1 got %0b exp 0", bus_a.out_in_ds_1); end
    vec++; if (bus_a.out_in_ds_2 !== 1'b0) begin errs++; $display("FAIL reset_ds2 got %0b exp 0", bus_a.out_in_ds_2); end
    vec++; if (bus_a.out_refetch !== 1'b0) begin errs++; $display("FAIL reset_refetch got %0b exp 0", bus_a.out_refetch); end
    vec++; if (bus_a.perf_dual_cnt !== 32'd0) begin errs++; $display("FAIL reset_perf_dual got %0d exp 0", bus_a.perf_dual_cnt); end
    tick();
  endtask

  task automatic test_basic();
    set_push(2'd2, dat(1), M_ALU, dat(2), M_ALU);
    #1;
    vec++; if (bus_a.out_valid_1 !== 1'b0) begin errs++; $display("FAIL basic_bypass got %0b exp 0", bus_a.out_valid_1); end
    tick();
    set_push(2'd0, '0, '0, '0, '0);
    #1;
    vec++; if (bus_a.out_valid_1 !== 1'b1) begin errs++; $display("FAIL basic_v1 got %0b exp 1", bus_a.out_valid_1); end
    vec++; if (bus_a.out_valid_2 !== 1'b1) begin errs++; $display("FAIL basic_v2 got %0b exp 1", bus_a.out_valid_2); end
    vec++; if (bus_a.out_data_1 !== dat(1)) begin errs++; $display("FAIL basic_d1 got %h exp %h", bus_a.out_data_1, dat(1)); end
    vec++; if (bus_a.out_data_2 !== dat(2)) begin errs++; $display("FAIL basic_d2 got %h exp %h", bus_a.out_data_2, dat(2)); end
    vec++; if (bus_a.out_in_ds_2 !== 1'b0) begin errs++; $display("FAIL basic_ds2 got %0b exp 0", bus_a.out_in_ds_2); end
    tick();
    #1;
    vec++; if (bus_a.out_valid_1 !== 1'b0) begin errs++; $display("FAIL basic_empty got %0b exp 0", bus_a.out_valid_1); end
    vec++; if (bus_a.push_ready !== 1'b1) begin errs++; $display("FAIL basic_ready got %0b exp 1", bus_a.push_ready); end
    tick();
  endtask

  task automatic test_pairing();
    logic [18:0] m0 [5];
    logic [18:0] m1 [5];
    logic        ev2 [5];
    m0[0] = {4'b0001, 5'd5, 5'd1, 5'd2}; m1[0] = {4'b0000, 5'd0, 5'd5, 5'd2}; ev2[0] = 1'b0;
    m0[1] = {4'b0001, 5'd7, 5'd1, 5'd2}; m1[1] = {4'b0000, 5'd0, 5'd1, 5'd7}; ev2[1] = 1'b0;
    m0[2] = {4'b0001, 5'd0, 5'd1, 5'd2}; m1[2] = {4'b0000, 5'd0, 5'd0, 5'd0}; ev2[2] = 1'b1;
    m0[3] = M_ALU;                       m1[3] = M_SOLO;                      ev2[3] = 1'b0;
    m0[4] = {4'b0000, 5'd5, 5'd1, 5'd2}; m1[4] = {4'b0000, 5'd0, 5'd5, 5'd2}; ev2[4] = 1'b1;
    for (int i = 0; i < 5; i++) begin
      bus_a.stall = 1'b1;
      set_push(2'd2, dat(10 + 2*i), m0[i], dat(11 + 2*i), m1[i]);
      tick();
      set_push(2'd0, '0, '0, '0, '0);
      bus_a.stall = 1'b0;
      #1;
      vec++; if (bus_a.out_valid_1 !== 1'b1) begin errs++; $display("FAIL pair%0d_v1 got %0b exp 1", i, bus_a.out_valid_1); end
      vec++; if (bus_a.out_valid_2 !== ev2[i]) begin errs++; $display("FAIL pair%0d_v2 got %0b exp %0b", i, bus_a.out_valid_2, ev2[i]); end
      vec++; if (bus_a.out_data_1 !== dat(10 + 2*i)) begin errs++; $display("FAIL pair%0d_d1 got %h exp %h", i, bus_a.out_data_1, dat(10 + 2*i)); end
      tick();
      #1;
      if (ev2[i]) begin
        vec++; if (bus_a.out_valid_1 !== 1'b0) begin errs++; $display("FAIL pair%0d_drained got %0b exp 0", i, bus_a.out_valid_1); end
      end else begin
        vec++; if (bus_a.out_valid_1 !== 1'b1) begin errs++; $display("FAIL pair%0d_second_v1 got %0b exp 1", i, bus_a.out_valid_1); end
        vec++; if (bus_a.out_data_1 !== dat(11 + 2*i)) begin errs++; $display("FAIL pair%0d_second_d1 got %h exp %h", i, bus_a.out_data_1, dat(11 + 2*i)); end
        tick();
        #1;
        vec++; if (bus_a.out_valid_1 !== 1'b0) begin errs++; $display("FAIL pair%0d_drained got %0b exp 0", i, bus_a.out_valid_1); end
      end
      tick();
    end
  endtask

  task automatic test_delay_slot();
    set_push(2'd1, dat(20), M_JMP, '0, '0);
    tick();
    set_push(2'd0, '0, '0, '0, '0);
    #1;
    vec++; if (bus_a.out_valid_1 !== 1'b1) begin errs++; $display("FAIL ds_jmp_v1 got %0b exp 1", bus_a.out_valid_1); end
    vec++; if (bus_a.out_valid_2 !== 1'b0) begin errs++; $display("FAIL ds_jmp_v2 got %0b exp 0", bus_a.out_valid_2); end
    vec++; if (bus_a.out_in_ds_1 !== 1'b0) begin errs++; $display("FAIL ds_jmp_ds1 got %0b exp 0", bus_a.out_in_ds_1); end
    tick();
    bus_a.stall = 1'b1;
    for (int i = 0; i < 3; i++) begin
      #1;
      vec++; if (bus_a.out_in_ds_1 !== 1'b1) begin errs++; $display("FAIL ds_stall%0d got %0b exp 1", i, bus_a.out_in_ds_1); end
      tick();
    end
    bus_a.stall = 1'b0;
    set_push(2'd1, dat(21), M_ALU, '0, '0);
    #1;
    vec++; if (bus_a.out_in_ds_1 !== 1'b1) begin errs++; $display("FAIL ds_bubble got %0b exp 1", bus_a.out_in_ds_1); end
    tick();
    set_push(2'd0, '0, '0, '0, '0);
    #1;
    vec++; if (bus_a.out_valid_1 !== 1'b1) begin errs++; $display("FAIL ds_slot_v1 got %0b exp 1", bus_a.out_valid_1); end
    vec++; if (bus_a.out_data_1 !== dat(21)) begin errs++; $display("FAIL ds_slot_d1 got %h exp %h", bus_a.out_data_1, dat(21)); end
    vec++; if (bus_a.out_in_ds_1 !== 1'b1) begin errs++; $display("FAIL ds_slot_ds1 got %0b exp 1", bus_a.out_in_ds_1); end
    tick();
    #1;
    vec++; if (bus_a.out_in_ds_1 !== 1'b0) begin errs++; $display("FAIL ds_cleared got %0b exp 0", bus_a.out_in_ds_1); end
    tick();
    set_push(2'd2, dat(22), M_JMP, dat(23), M_ALU);
    tick();
    set_push(2'd0, '0, '0, '0, '0);
    #1;
    vec++; if (bus_a.out_valid_2 !== 1'b1) begin errs++; $display("FAIL ds_pair_v2 got %0b exp 1", bus_a.out_valid_2); end
    vec++; if (bus_a.out_in_ds_2 !== 1'b1) begin errs++; $display("FAIL ds_pair_ds2 got %0b exp 1", bus_a.out_in_ds_2); end
    vec++; if (bus_a.out_in_ds_1 !== 1'b0) begin errs++; $display("FAIL ds_pair_ds1 got %0b exp 0", bus_a.out_in_ds_1); end
    tick();
    #1;
    vec++; if (bus_a.out_in_ds_1 !== 1'b0) begin errs++; $display("FAIL ds_pair_after got %0b exp 0", bus_a.out_in_ds_1); end
    tick();
    set_push(2'd2, dat(24), M_ALU, dat(25), M_JMP);
    tick();
    set_push(2'd0, '0, '0, '0, '0);
    #1;
    vec++; if (bus_a.out_valid_2 !== 1'b0) begin errs++; $display("FAIL ds_jmp_h1_v2 got %0b exp 0", bus_a.out_valid_2); end
    tick();
    #1;
    vec++; if (bus_a.out_data_1 !== dat(25)) begin errs++; $display("FAIL ds_jmp_h1_d1 got %h exp %h", bus_a.out_data_1, dat(25)); end
    tick();
    #1;
    vec++; if (bus_a.out_in_ds_1 !== 1'b1) begin errs++; $display("FAIL ds_before_flush got %0b exp 1", bus_a.out_in_ds_1); end
    bus_a.flush = 1'b1;
    tick();
    bus_a.flush = 1'b0;
    #1;
    vec++; if (bus_a.out_in_ds_1 !== 1'b0) begin errs++; $display("FAIL ds_flush got %0b exp 0", bus_a.out_in_ds_1); end
    tick();
  endtask

  task automatic test_fill_flush();
    bus_a.stall = 1'b1;
    for (int i = 0; i < 7; i++) begin
      set_push(2'd2, dat(100 + 2*i), M_ALU, dat(101 + 2*i), M_ALU);
      #1;
      vec++; if (bus_a.push_ready !== 1'b1) begin errs++; $display("FAIL fill_ready%0d got %0b exp 1", i, bus_a.push_ready); end
      tick();
    end
    set_push(2'd1, dat(114), M_ALU, '0, '0);
    #1;
    vec++; if (bus_a.push_ready !== 1'b1) begin errs++; $display("FAIL fill_ready14 got %0b exp 1", bus_a.push_ready); end
    tick();
    set_push(2'd2, dat(900), M_ALU, dat(901), M_ALU);
    #1;
    vec++; if (bus_a.push_ready !== 1'b0) begin errs++; $display("FAIL fill_ready15 got %0b exp 0", bus_a.push_ready); end
    tick();
    set_push(2'd1, dat(902), M_ALU, '0, '0);
    #1;
    vec++; if (bus_a.push_ready !== 1'b0) begin errs++; $display("FAIL fill_dropped got %0b exp 0", bus_a.push_ready); end
    tick();
    set_push(2'd0, '0, '0, '0, '0);
    bus_a.stall = 1'b0;
    for (int k = 0; k < 7; k++) begin
      #1;
      vec++; if (bus_a.out_valid_2 !== 1'b1) begin errs++; $display("FAIL drain%0d_v2 got %0b exp 1", k, bus_a.out_valid_2); end
      vec++; if (bus_a.out_data_1 !== dat(100 + 2*k)) begin errs++; $display("FAIL drain%0d_d1 got %h exp %h", k, bus_a.out_data_1, dat(100 + 2*k)); end
      vec++; if (bus_a.out_data_2 !== dat(101 + 2*k)) begin errs++; $display("FAIL drain%0d_d2 got %h exp %h", k, bus_a.out_data_2, dat(101 + 2*k)); end
      tick();
    end
    #1;
    vec++; if (bus_a.out_valid_1 !== 1'b1 || bus_a.out_valid_2 !== 1'b0) begin errs++; $display("FAIL drain_last got %0b%0b exp 10", bus_a.out_valid_1, bus_a.out_valid_2); end
    vec++; if (bus_a.out_data_1 !== dat(114)) begin errs++; $display("FAIL drain_last_d1 got %h exp %h", bus_a.out_data_1, dat(114)); end
    tick();
    #1;
    vec++; if (bus_a.out_valid_1 !== 1'b0) begin errs++; $display("FAIL drain_empty got %0b exp 0", bus_a.out_valid_1); end
    tick();
    bus_a.stall = 1'b1;
    set_push(2'd2, dat(30), M_ALU, dat(31), M_ALU);
    tick();
    bus_a.flush = 1'b1;
    bus_a.stall = 1'b0;
    set_push(2'd2, dat(32), M_ALU, dat(33), M_ALU);
    #1;
    vec++; if (bus_a.out_valid_1 !== 1'b0) begin errs++; $display("FAIL flush_v1 got %0b exp 0", bus_a.out_valid_1); end
    tick();
    bus_a.flush = 1'b0;
    set_push(2'd0, '0, '0, '0, '0);
    #1;
    vec++; if (bus_a.out_valid_1 !== 1'b0) begin errs++; $display("FAIL flush_after_v1 got %0b exp 0", bus_a.out_valid_1); end
    vec++; if (bus_a.push_ready !== 1'b1) begin errs++; $display("FAIL flush_ready got %0b exp 1", bus_a.push_ready); end
    tick();
    set_push(2'd2, dat(34), M_ALU, dat(35), M_ALU);
    tick();
    set_push(2'd0, '0, '0, '0, '0);
    #1;
    vec++; if (bus_a.out_valid_2 !== 1'b1) begin errs++; $display("FAIL flush_refill_v2 got %0b exp 1", bus_a.out_valid_2); end
    vec++; if (bus_a.out_data_1 !== dat(34)) begin errs++; $display("FAIL flush_refill_d1 got %h exp %h", bus_a.out_data_1, dat(34)); end
    vec++; if (bus_a.out_data_2 !== dat(35)) begin errs++; $display("FAIL flush_refill_d2 got %h exp %h", bus_a.out_data_2, dat(35)); end
    tick();
  endtask

  task automatic test_refetch();
    set_push(2'd1, dat(40), M_SER, '0, '0);
    tick();
    set_push(2'd0, '0, '0, '0, '0);
    #1;
    vec++; if (bus_a.out_valid_1 !== 1'b1) begin errs++; $display("FAIL rf_issue got %0b exp 1", bus_a.out_valid_1); end
    vec++; if (bus_a.out_refetch !== 1'b0) begin errs++; $display("FAIL rf_early got %0b exp 0", bus_a.out_refetch); end
    tick();
    #1;
    vec++; if (bus_a.out_refetch !== 1'b1) begin errs++; $display("FAIL rf_set got %0b exp 1", bus_a.out_refetch); end
    tick();
    bus_a.flush = 1'b1;
    tick();
    bus_a.flush = 1'b0;
    #1;
    vec++; if (bus_a.out_refetch !== 1'b1) begin errs++; $display("FAIL rf_flush got %0b exp 1", bus_a.out_refetch); end
    bus_a.refetch_clr = 1'b1;
    tick();
    bus_a.refetch_clr = 1'b0;
    #1;
    vec++; if (bus_a.out_refetch !== 1'b0) begin errs++; $display("FAIL rf_clr got %0b exp 0", bus_a.out_refetch); end
    tick();
    set_push(2'd2, dat(41), M_ALU, dat(42), M_SER);
    tick();
    set_push(2'd0, '0, '0, '0, '0);
    #1;
    vec++; if (bus_a.out_valid_2 !== 1'b0) begin errs++; $display("FAIL rf_ser_h1_v2 got %0b exp 0", bus_a.out_valid_2); end
    tick();
    #1;
    vec++; if (bus_a.out_data_1 !== dat(42)) begin errs++; $display("FAIL rf_ser_d1 got %h exp %h", bus_a.out_data_1, dat(42)); end
    vec++; if (bus_a.out_refetch !== 1'b0) begin errs++; $display("FAIL rf_ser_pre got %0b exp 0", bus_a.out_refetch); end
    tick();
    set_push(2'd2, dat(43), M_SER, dat(44), M_ALU);
    #1;
    vec++; if (bus_a.out_refetch !== 1'b1) begin errs++; $display("FAIL rf_ser_post got %0b exp 1", bus_a.out_refetch); end
    tick();
    set_push(2'd0, '0, '0, '0, '0);
    bus_a.refetch_clr = 1'b1;
    #1;
    vec++; if (bus_a.out_valid_2 !== 1'b0) begin errs++; $display("FAIL rf_ser_h0_v2 got %0b exp 0", bus_a.out_valid_2); end
    tick();
    bus_a.refetch_clr = 1'b0;
    #1;
    vec++; if (bus_a.out_refetch !== 1'b1) begin errs++; $display("FAIL rf_set_wins got %0b exp 1", bus_a.out_refetch); end
    bus_a.refetch_clr = 1'b1;
    tick();
    bus_a.refetch_clr = 1'b0;
    #1;
    vec++; if (bus_a.out_refetch !== 1'b0) begin errs++; $display("FAIL rf_final_clr got %0b exp 0", bus_a.out_refetch); end
    tick();
  endtask

  task automatic test_single_issue();
    do_reset();
    bus_a.stall = 1'b1;
    set_push(2'd2, dat(50), M_ALU, dat(51), M_ALU);
    tick();
    set_push(2'd2, dat(52), M_ALU, dat(53), M_ALU);
    tick();
    set_push(2'd0, '0, '0, '0, '0);
    bus_a.stall = 1'b0;
    for (int k = 0; k < 4; k++) begin
      #1;
      vec++; if (bus_b.out_valid_1 !== 1'b1) begin errs++; $display("FAIL single%0d_v1 got %0b exp 1", k, bus_b.out_valid_1); end
      vec++; if (bus_b.out_valid_2 !== 1'b0) begin errs++; $display("FAIL single%0d_v2 got %0b exp 0", k, bus_b.out_valid_2); end
      vec++; if (bus_b.out_data_1 !== dat(50 + k)) begin errs++; $display("FAIL single%0d_d1 got %h exp %h", k, bus_b.out_data_1, dat(50 + k)); end
      tick();
    end
    #1;
    vec++; if (bus_b.out_valid_1 !== 1'b0) begin errs++; $display("FAIL single_empty got %0b exp 0", bus_b.out_valid_1); end
    tick();
  endtask

  task automatic test_perf();
    do_reset();
    for (int r = 0; r < 2; r++) begin
      bus_a.stall = 1'b1;
      for (int i = 0; i < 5; i++) begin
        set_push(2'd2, dat(60 + i), M_ALU, dat(70 + i), M_ALU);
        tick();
      end
      set_push(2'd0, '0, '0, '0, '0);
      bus_a.stall = 1'b0;
      for (int i = 0; i < 5; i++) tick();
    end
    bus_a.stall = 1'b1;
    for (int i = 0; i < 2; i++) begin
      set_push(2'd2, dat(80 + i), M_SOLO, dat(90 + i), M_SOLO);
      tick();
    end
    set_push(2'd0, '0, '0, '0, '0);
    bus_a.stall = 1'b0;
    for (int i = 0; i < 7; i++) tick();
    bus_a.stall = 1'b1;
    #1;
    vec++; if (bus_a.perf_dual_cnt !== (PERF ? 32'd10 : 32'd0)) begin errs++; $display("FAIL perf_dual got %0d exp %0d", bus_a.perf_dual_cnt, PERF ? 10 : 0); end
    vec++; if (bus_a.perf_single_cnt !== (PERF ? 32'd4 : 32'd0)) begin errs++; $display("FAIL perf_single got %0d exp %0d", bus_a.perf_single_cnt, PERF ? 4 : 0); end
    vec++; if (bus_a.perf_empty_cnt !== (PERF ? 32'd3 : 32'd0)) begin errs++; $display("FAIL perf_empty got %0d exp %0d", bus_a.perf_empty_cnt, PERF ? 3 : 0); end
    tick();
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog timeout at %0t", $time);
    $fatal(1, "timeout");
  end

  initial begin
    test_reset();
    test_basic();
    test_pairing();
    test_delay_slot();
    test_fill_flush();
    test_refetch();
    test_single_issue();
    test_perf();
    $display("== %0d vectors applied, %0d miscompares ==", vec, errs);
    $finish;
  end
endmodule
